// File: rtl/led_color_sequencer_pkg.sv
// Shared color definitions for the LED color sequencer.
// Provides the LED_COLOR enum, the 24-bit {R,G,B} color type, the per-channel
// type, the sequencer state enum and the enum-to-RGB lookup getColorCode.
package led_color_sequencer_pkg;

  typedef logic [23:0] color;
  typedef logic [7:0]  channel_t;

  typedef enum logic [3:0] {
    LED_OFF     = 4'd0,
    LED_RED     = 4'd1,
    LED_GREEN   = 4'd2,
    LED_BLUE    = 4'd3,
    LED_YELLOW  = 4'd4,
    LED_CYAN    = 4'd5,
    LED_MAGENTA = 4'd6,
    LED_WHITE   = 4'd7,
    LED_ORANGE  = 4'd8,
    LED_PURPLE  = 4'd9
  } LED_COLOR;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    FADE = 2'd2
  } seq_state_e;

  localparam color COLOR_OFF = 24'h000000;

  // Unused enum encodings map to black so a corrupt table entry stays dark.
  function automatic color getColorCode(input LED_COLOR c);
    color code;
    case (c)
      LED_RED:     code = 24'hFF0000;
      LED_GREEN:   code = 24'h00FF00;
      LED_BLUE:    code = 24'h0000FF;
      LED_YELLOW:  code = 24'hFFFF00;
      LED_CYAN:    code = 24'h00FFFF;
      LED_MAGENTA: code = 24'hFF00FF;
      LED_WHITE:   code = 24'hFFFFFF;
      LED_ORANGE:  code = 24'hFF8000;
      LED_PURPLE:  code = 24'h8000FF;
      default:     code = COLOR_OFF;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/led_color_sequencer_color_lerp.sv
// color_lerp: combinational linear interpolator between two RGB colors.
// Ports:
//   i_a   - start color {R,G,B}
//   i_b   - end color {R,G,B}
//   i_k   - fade position, 0..2^FADE_SHIFT-1
//   o_out - per channel: a + (((b - a) * k) >>> FADE_SHIFT)
module color_lerp
  import led_color_sequencer_pkg::*;
#(
  parameter int FADE_SHIFT = 4
) (
  input  color                  i_a,
  input  color                  i_b,
  input  logic [FADE_SHIFT-1:0] i_k,
  output color                  o_out
);

  localparam int PW = 9 + FADE_SHIFT;

  // |b-a| <= 255 and k < 2^FADE_SHIFT, so the product fits in PW signed bits
  // and the shifted result added to a always lands in 0..255.
  function automatic channel_t lerp_ch(input channel_t a, input channel_t b,
                                       input logic [FADE_SHIFT-1:0] k);
    logic signed [8:0]    d9;
    logic signed [PW-1:0] diff;
    logic signed [PW-1:0] kk;
    logic signed [PW-1:0] prod;
    d9   = $signed({1'b0, b}) - $signed({1'b0, a});
    diff = {{FADE_SHIFT{d9[8]}}, d9};
    kk   = {9'b0, k};
    prod = diff * kk;
    return channel_t'($signed({{(FADE_SHIFT + 1){1'b0}}, a}) + (prod >>> FADE_SHIFT));
  endfunction

  for (genvar c = 0; c < 3; c++) begin : g_ch
    assign o_out[c*8 +: 8] = lerp_ch(i_a[c*8 +: 8], i_b[c*8 +: 8], i_k);
  end

endmodule

// File: rtl/led_color_sequencer.sv
// led_color_sequencer: plays a programmable table of LED_COLOR steps onto one
// 24-bit RGB output, holding each step for its dwell time and optionally
// crossfading linearly into the next step.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   cfg_we/addr/color/dwell - write one step-table entry
//   num_steps     - number of active entries (0..NUM_STEPS)
//   fade_en       - crossfade between steps when high
//   start, stop   - one-cycle control pulses (stop has priority)
//   busy          - high while holding or fading
//   rgb_o         - registered {R,G,B} output
//   step_idx      - current step, or the step being faded from
//   wrap          - one-cycle pulse when the sequence returns to step 0
module led_color_sequencer
  import led_color_sequencer_pkg::*;
#(
  parameter int NUM_STEPS  = 8,
  parameter int DWELL_W    = 16,
  parameter int FADE_SHIFT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_STEPS)-1:0] cfg_addr,
  input  LED_COLOR                     cfg_color,
  input  logic [DWELL_W-1:0]           cfg_dwell,
  input  logic [$clog2(NUM_STEPS):0]   num_steps,
  input  logic                         fade_en,
  input  logic                         start,
  input  logic                         stop,
  output logic                         busy,
  output color                         rgb_o,
  output logic [$clog2(NUM_STEPS)-1:0] step_idx,
  output logic                         wrap
);

  localparam int IW = $clog2(NUM_STEPS);
  localparam logic [IW-1:0]         IDX_ONE = IW'(1);
  localparam logic [IW:0]           NS_ONE  = (IW + 1)'(1);
  localparam logic [DWELL_W-1:0]    DW_ONE  = DWELL_W'(1);
  localparam logic [FADE_SHIFT-1:0] K_ONE   = FADE_SHIFT'(1);
  localparam logic [FADE_SHIFT-1:0] K_LAST  = '1;

  // Step table
  LED_COLOR           r_tbl_color [NUM_STEPS];
  logic [DWELL_W-1:0] r_tbl_dwell [NUM_STEPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        r_tbl_color[i] <= LED_OFF;
        r_tbl_dwell[i] <= '0;
      end
    end else if (cfg_we) begin
      r_tbl_color[cfg_addr] <= cfg_color;
      r_tbl_dwell[cfg_addr] <= cfg_dwell;
    end
  end

  // Sequencer state
  seq_state_e            r_state;
  logic [DWELL_W-1:0]    r_cnt;       // hold cycles left, including the current one
  logic [FADE_SHIFT-1:0] r_k;         // fade position currently on rgb_o
  color                  r_cur_code;  // color of the step being held / faded from
  color                  r_nxt_code;  // fade target, sampled on fade entry
  logic [IW-1:0]         r_nxt_idx;
  logic                  r_nxt_wrap;

  logic                  w_last;
  logic [IW-1:0]         w_next;
  logic [IW-1:0]         w_hold_idx;
  color                  w_hold_code;
  logic [DWELL_W-1:0]    w_hold_dwell;
  logic                  w_enter_hold;
  logic                  w_enter_fade;
  logic                  w_hold_wrap;
  color                  w_lerp_b;
  logic [FADE_SHIFT-1:0] w_lerp_k;
  color                  w_lerp;

  // num_steps is re-read at every advance; an index at or beyond the new
  // last entry (including num_steps = 0) wraps back to step 0.
  assign w_last = (num_steps == '0) || (({1'b0, step_idx} + NS_ONE) >= num_steps);
  assign w_next = w_last ? '0 : step_idx + IDX_ONE;

  // Entry sampled on HOLD entry: step 0 from IDLE, the advance target from
  // HOLD, or the index captured when the fade began.
  always_comb begin
    w_hold_idx = '0;
    case (r_state)
      HOLD:    w_hold_idx = w_next;
      FADE:    w_hold_idx = r_nxt_idx;
      default: w_hold_idx = '0;
    endcase
  end

  assign w_hold_code  = getColorCode(r_tbl_color[w_hold_idx]);
  assign w_hold_dwell = (r_tbl_dwell[w_hold_idx] == '0) ? DW_ONE : r_tbl_dwell[w_hold_idx];

  always_comb begin
    w_enter_hold = 1'b0;
    w_enter_fade = 1'b0;
    w_hold_wrap  = 1'b0;
    case (r_state)
      IDLE: w_enter_hold = start && (num_steps != '0);
      HOLD: begin
        if (r_cnt == DW_ONE) begin
          if (fade_en) begin
            w_enter_fade = 1'b1;
          end else begin
            w_enter_hold = 1'b1;
            w_hold_wrap  = w_last;
          end
        end
      end
      FADE: begin
        if (r_k == K_LAST) begin
          w_enter_hold = 1'b1;
          w_hold_wrap  = r_nxt_wrap;
        end
      end
      default: ;
    endcase
  end

  // One interpolator serves both fade entry (k=1 toward the freshly looked-up
  // target) and the remaining fade cycles (k+1 toward the captured target).
  assign w_lerp_b = (r_state == HOLD) ? w_hold_code : r_nxt_code;
  assign w_lerp_k = (r_state == HOLD) ? K_ONE : r_k + K_ONE;

  color_lerp #(
    .FADE_SHIFT(FADE_SHIFT)
  ) u_lerp (
    .i_a  (r_cur_code),
    .i_b  (w_lerp_b),
    .i_k  (w_lerp_k),
    .o_out(w_lerp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_nxt_wrap <= 1'b0;
      busy       <= 1'b0;
      rgb_o      <= COLOR_OFF;
      step_idx   <= '0;
      wrap       <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (stop) begin
        r_state  <= IDLE;
        busy     <= 1'b0;
        rgb_o    <= COLOR_OFF;
        step_idx <= '0;
      end else if (w_enter_hold) begin
        r_state    <= HOLD;
        busy       <= 1'b1;
        step_idx   <= w_hold_idx;
        rgb_o      <= w_hold_code;
        r_cur_code <= w_hold_code;
        r_cnt      <= w_hold_dwell;
        wrap       <= w_hold_wrap;
      end else if (w_enter_fade) begin
        r_state    <= FADE;
        r_k        <= K_ONE;
        r_nxt_idx  <= w_next;
        r_nxt_wrap <= w_last;
        r_nxt_code <= w_hold_code;
        rgb_o      <= w_lerp;
      end else begin
        case (r_state)
          HOLD: r_cnt <= r_cnt - DW_ONE;
          FADE: begin
            r_k   <= r_k + K_ONE;
            rgb_o <= w_lerp;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_color_sequencer.sv
module tb_led_color_sequencer;
  import led_color_sequencer_pkg::*;

  localparam int NS = 8;
  localparam int DW = 16;
  localparam int FS = 2;
  localparam int S  = 1 << FS;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [2:0]    cfg_addr;
  LED_COLOR      cfg_color;
  logic [DW-1:0] cfg_dwell;
  logic [3:0]    num_steps;
  logic          fade_en;
  logic          start;
  logic          stop;
  logic          busy;
  color          rgb_o;
  logic [2:0]    step_idx;
  logic          wrap;

  led_color_sequencer #(
    .NUM_STEPS(NS),
    .DWELL_W(DW),
    .FADE_SHIFT(FS)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_color(cfg_color), .cfg_dwell(cfg_dwell), .num_steps(num_steps),
    .fade_en(fade_en), .start(start), .stop(stop), .busy(busy),
    .rgb_o(rgb_o), .step_idx(step_idx), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference table contents
  int m_color [NS];
  int m_dwell [NS];

  // Expected per-cycle outputs after a start
  logic [23:0] e_rgb [$];
  int          e_idx [$];
  bit          e_wrap [$];

  function automatic logic [23:0] code_of(int c);
    case (c)
      1: return 24'hFF0000;
      2: return 24'h00FF00;
      3: return 24'h0000FF;
      4: return 24'hFFFF00;
      5: return 24'h00FFFF;
      6: return 24'hFF00FF;
      7: return 24'hFFFFFF;
      8: return 24'hFF8000;
      9: return 24'h8000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // a + floor((b-a)*k / 2^FS), done with integer division
  function automatic int lerp_ch(int a, int b, int k);
    int p;
    int q;
    p = (b - a) * k;
    if (p >= 0) q = p / S;
    else        q = -((-p + S - 1) / S);
    return a + q;
  endfunction

  function automatic logic [23:0] lerp24(logic [23:0] a, logic [23:0] b, int k);
    logic [23:0] r;
    int v;
    for (int ch = 0; ch < 3; ch++) begin
      v = lerp_ch(int'(a[ch*8 +: 8]), int'(b[ch*8 +: 8]), k);
      r[ch*8 +: 8] = v[7:0];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(int a, int c, int d);
    cfg_we    = 1'b1;
    cfg_addr  = a[2:0];
    cfg_color = LED_COLOR'(c[3:0]);
    cfg_dwell = d[DW-1:0];
    tick();
    cfg_we    = 1'b0;
    m_color[a] = c;
    m_dwell[a] = d;
  endtask

  task automatic build_expected(int ns, bit fe, int n);
    int idx;
    int d;
    int nxt;
    bit wf;
    e_rgb.delete();
    e_idx.delete();
    e_wrap.delete();
    idx = 0;
    wf  = 1'b0;
    while (e_rgb.size() < n) begin
      d = (m_dwell[idx] == 0) ? 1 : m_dwell[idx];
      for (int j = 0; j < d; j++) begin
        e_rgb.push_back(code_of(m_color[idx]));
        e_idx.push_back(idx);
        e_wrap.push_back((j == 0) && wf);
      end
      nxt = (idx >= ns - 1) ? 0 : idx + 1;
      if (fe) begin
        for (int k = 1; k < S; k++) begin
          e_rgb.push_back(lerp24(code_of(m_color[idx]), code_of(m_color[nxt]), k));
          e_idx.push_back(idx);
          e_wrap.push_back(1'b0);
        end
      end
      wf  = (nxt == 0);
      idx = nxt;
    end
  endtask

  // Start a run, compare n cycles against the reference, then stop it.
  task automatic run_and_check(string name, int ns, bit fe, int n);
    build_expected(ns, fe, n);
    num_steps = ns[3:0];
    fade_en   = fe;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick();
      checks += 4;
      if (rgb_o !== e_rgb[i]) begin
        errors++;
        $display("FAIL %s cyc%0d rgb_o: got %06h want %06h", name, i, rgb_o, e_rgb[i]);
      end
      if (step_idx !== 3'(e_idx[i])) begin
        errors++;
        $display("FAIL %s cyc%0d step_idx: got %0d want %0d", name, i, step_idx, e_idx[i]);
      end
      if (wrap !== e_wrap[i]) begin
        errors++;
        $display("FAIL %s cyc%0d wrap: got %0b want %0b", name, i, wrap, e_wrap[i]);
      end
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s cyc%0d busy: got %0b want 1", name, i, busy);
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks += 2;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s stop busy: got %0b want 0", name, busy);
    end
    if (rgb_o !== 24'h000000) begin
      errors++;
      $display("FAIL %s stop rgb_o: got %06h want 000000", name, rgb_o);
    end
  endtask

  task automatic check_idle_outputs(string name);
    checks += 4;
    if (rgb_o !== 24'h000000) begin errors++; $display("FAIL %s rgb_o: got %06h want 000000", name, rgb_o); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL %s busy: got %0b want 0", name, busy); end
    if (step_idx !== 3'd0)    begin errors++; $display("FAIL %s step_idx: got %0d want 0", name, step_idx); end
    if (wrap !== 1'b0)        begin errors++; $display("FAIL %s wrap: got %0b want 0", name, wrap); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    check_idle_outputs("reset_held");
    rst = 1'b0;
    tick();
    check_idle_outputs("reset_released");
    for (int i = 0; i < NS; i++) begin
      m_color[i] = 0;
      m_dwell[i] = 0;
    end
  endtask

  task automatic test_basic_hold();
    write_entry(0, 1, 3);
    write_entry(1, 2, 2);
    run_and_check("basic_hold", 2, 1'b0, 15);
  endtask

  task automatic test_fade_values();
    logic [23:0] obs [6];
    logic [23:0] want [6];
    want[0] = 24'hFF0000; want[1] = 24'hFF0000;
    want[2] = 24'hBF003F; want[3] = 24'h7F007F; want[4] = 24'h3F00BF;
    want[5] = 24'h0000FF;
    write_entry(0, 1, 2);
    write_entry(1, 3, 2);
    num_steps = 4'd2;
    fade_en   = 1'b1;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      obs[i] = rgb_o;
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs[i] !== want[i]) begin
        errors++;
        $display("FAIL fade_values cyc%0d rgb_o: got %06h want %06h", i, obs[i], want[i]);
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    run_and_check("fade_model", 2, 1'b1, 24);
  endtask

  task automatic test_num_steps_zero();
    num_steps = 4'd0;
    fade_en   = 1'b0;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    check_idle_outputs("ns_zero_t1");
    tick();
    tick();
    check_idle_outputs("ns_zero_t3");
  endtask

  task automatic test_stop();
    // stop and start together: stop wins
    num_steps = 4'd2;
    fade_en   = 1'b1;
    start     = 1'b1;
    stop      = 1'b1;
    tick();
    start     = 1'b0;
    stop      = 1'b0;
    check_idle_outputs("stop_with_start");
    // stop in the middle of a fade (entries RED/2, BLUE/2 still loaded)
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (rgb_o !== 24'h7F007F) begin
      errors++;
      $display("FAIL stop_mid_fade pre rgb_o: got %06h want 7F007F", rgb_o);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle_outputs("stop_mid_fade");
    tick();
    check_idle_outputs("stop_mid_fade_after");
  endtask

  task automatic test_reset_midrun();
    write_entry(0, 5, 6);
    write_entry(1, 6, 6);
    write_entry(2, 7, 6);
    num_steps = 4'd3;
    fade_en   = 1'b0;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("reset_midrun");
    for (int i = 0; i < NS; i++) begin
      m_color[i] = 0;
      m_dwell[i] = 0;
    end
    run_and_check("cleared_table", 3, 1'b0, 9);
  endtask

  task automatic test_rewrite_active();
    logic [23:0] want [12];
    want[0] = 24'hFF0000; want[1] = 24'hFF0000; want[2]  = 24'hFF0000; want[3]  = 24'hFF0000;
    want[4] = 24'h0000FF; want[5] = 24'h0000FF;
    want[6] = 24'h00FF00; want[7] = 24'h00FF00; want[8]  = 24'h00FF00; want[9]  = 24'h00FF00;
    want[10] = 24'h0000FF; want[11] = 24'h0000FF;
    write_entry(0, 1, 4);
    write_entry(1, 3, 2);
    num_steps = 4'd2;
    fade_en   = 1'b0;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) begin
        write_entry(0, 2, 4);
      end else if (i > 0) begin
        tick();
      end
      checks++;
      if (rgb_o !== want[i]) begin
        errors++;
        $display("FAIL rewrite_active cyc%0d rgb_o: got %06h want %06h", i, rgb_o, want[i]);
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_num_steps_change();
    int want_idx  [6];
    bit want_wrap [6];
    want_idx  = '{0, 1, 2, 0, 1, 0};
    want_wrap = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    write_entry(0, 1, 1);
    write_entry(1, 2, 1);
    write_entry(2, 3, 1);
    write_entry(3, 4, 1);
    num_steps = 4'd4;
    fade_en   = 1'b0;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      if (i == 2) num_steps = 4'd2;
      // start while running must be ignored
      start = (i == 4);
      checks += 2;
      if (step_idx !== 3'(want_idx[i])) begin
        errors++;
        $display("FAIL ns_change cyc%0d step_idx: got %0d want %0d", i, step_idx, want_idx[i]);
      end
      if (wrap !== want_wrap[i]) begin
        errors++;
        $display("FAIL ns_change cyc%0d wrap: got %0b want %0b", i, wrap, want_wrap[i]);
      end
    end
    start = 1'b0;
    stop  = 1'b1;
    tick();
    stop  = 1'b0;
  endtask

  task automatic test_random();
    int ns;
    bit fe;
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < NS; a++) begin
        write_entry(a, int'($urandom_range(0, 9)), int'($urandom_range(0, 5)));
      end
      ns = (it == 0) ? 1 : int'($urandom_range(1, NS));
      fe = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      run_and_check($sformatf("random%0d", it), ns, fe, 60);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_color = LED_OFF;
    cfg_dwell = '0;
    num_steps = '0;
    fade_en   = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;

    test_reset();
    test_basic_hold();
    test_fade_values();
    test_num_steps_zero();
    test_stop();
    test_reset_midrun();
    test_rewrite_active();
    test_num_steps_change();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_color_sequencer.md
# led_color_sequencer

Sequences a programmable list of `LED_COLOR` steps onto a single 24-bit RGB LED driver output. Each step is held for its own dwell time, with optional linear crossfade to the next step. Color codes come from the shared color package (`getColorCode`). The block sits between the register/config interface and the LED PWM driver. It is the sole source of `rgb_o` for one LED.

## Interface
Parameters:
- `NUM_STEPS`, 8: depth of the step table; power of two, 2..64.
- `DWELL_W`, 16: width of the per-step dwell counter, in clock cycles.
- `FADE_SHIFT`, 4: a fade lasts 2^FADE_SHIFT−1 cycles; range 1..8.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `cfg_we`, in, 1: write strobe for one step-table entry.
- `cfg_addr`, in, $clog2(NUM_STEPS): entry index to write.
- `cfg_color`, in, `LED_COLOR`: color for the entry.
- `cfg_dwell`, in, DWELL_W: hold cycles for the entry.
- `num_steps`, in, $clog2(NUM_STEPS)+1: active entries, 0..NUM_STEPS.
- `fade_en`, in, 1: crossfade between steps when high.
- `start`, in, 1: one-cycle pulse to begin at step 0.
- `stop`, in, 1: one-cycle pulse to abort.
- `busy`, out, 1: high in HOLD or FADE.
- `rgb_o`, out, 24 (`color`): registered RGB code, {R,G,B}.
- `step_idx`, out, $clog2(NUM_STEPS): index of the current step, or the step being faded from.
- `wrap`, out, 1: one-cycle pulse when the sequence moves from the last step to step 0.

## Operation
- FSM states: IDLE, HOLD, FADE.
- IDLE:
  - `start` with `num_steps`≠0 → HOLD with idx=0.
  - `start` with `num_steps`=0 is ignored.
  - `start` is ignored in HOLD/FADE.
- HOLD:
  - On entry, latch the entry's color and dwell; `rgb_o`=getColorCode(color).
  - Stay dwell cycles; dwell=0 is treated as 1.
  - At expiry, next=(idx==num_steps−1)?0:idx+1.
  - If `fade_en`: → FADE. Otherwise: → HOLD(next).
- FADE:
  - k runs 1..2^FADE_SHIFT−1, one step per cycle.
  - Per 8-bit channel: out = a + ((b−a)·k) >>> FADE_SHIFT.
  - a = current color, b = next color.
  - b−a is a 9-bit signed value; the product is 9+FADE_SHIFT bits signed; arithmetic shift; result is always in 0..255, with no clamping needed.
  - After the last k → HOLD(next); `rgb_o` is then exactly the code of b.
- `num_steps`=1: the sequence loops on entry 0. If `fade_en`, it fades a→a, so output is constant.
- `wrap` pulses in the cycle HOLD(0) is entered from the last index. It does not pulse on the initial `start`.
- Config writes:
  - Accepted in any state.
  - An entry is sampled only on HOLD entry; the next-color code is sampled on FADE entry.
  - A write to the current entry affects only its next visit.
- `num_steps` changed mid-run: compared at each step advance. If idx ≥ new `num_steps`−1, the next step is 0.
- `stop` in any state → IDLE on the next cycle.
- `stop` and `start` in the same cycle: `stop` wins.
- Reset and IDLE:
  - `rgb_o`=0, `busy`=0, `step_idx`=0, `wrap`=0.
  - Reset also clears every table entry to enum value 0 with dwell 0.

## Timing
- `start` at cycle t: `busy`=1 and `rgb_o`=code(entry0) at t+1.
- HOLD of dwell D occupies exactly D cycles of `rgb_o`.
- FADE occupies 2^FADE_SHIFT−1 cycles.
- Step period: D, or D+2^FADE_SHIFT−1 with `fade_en`.
- `stop` at t: `rgb_o`=0 and `busy`=0 at t+1.
- `rst` asserted mid-run: all outputs at reset values on the next edge, with no partial fade.
- Table write at t is visible to a HOLD entry at t+1 or later.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package: `LED_COLOR` enum, `color` (24-bit) typedef, `getColorCode`, `channel_t` (8-bit), `seq_state_e`.
- Package constant: `COLOR_OFF`=24'h000000.
- Sub-module `color_lerp`: a combinational per-channel interpolator (a, b, k → out), instantiated once for 3 channels.
- Step table is a flop array with synchronous reset.

## Test plan
- Table {RED,D=3},{GREEN,D=2}, `num_steps`=2, `fade_en`=0, `start` → `rgb_o` FF0000×3, 00FF00×2, FF0000…; `wrap` pulses on each return to RED.
- FADE_SHIFT=2, RED→BLUE with `fade_en`=1 → three fade cycles: BF003F, 7F007F, 3F00BF; then 0000FF exact.
- `num_steps`=0 with `start` → stays IDLE, `busy`=0, `rgb_o`=000000.
- `stop` asserted together with `start`, and `stop` mid-FADE → IDLE and `rgb_o`=0 the next cycle.
- `rst` mid-HOLD → all outputs 0 at the next edge; a subsequent `start` plays the cleared table (enum 0, dwell treated as 1).
- Rewrite entry 0 to GREEN while entry 0 is active → current hold is unchanged; next visit outputs 00FF00.
